mesh_core_sink: RTL and testbench

Downstream receiver for one mesh router output port, normally the core port. It terminates the router's valid/enable flow control and buffers accepted packets in a small FIFO for the local core to drain. It checks every packet for correct destination and in-order delivery per source, and keeps a saturating receive count. It is used in router and mesh benches as the self-checking counterpart to the random packet injectors, and it is synthesizable so it can stand in as a minimal core endpoint.

---
 rtl/mesh_core_sink_pkg.sv | 25 ++
 rtl/mesh_core_sink_fifo.sv | 65 ++++++
 rtl/mesh_core_sink.sv | 120 ++++++++++++
 tb/tb_mesh_core_sink.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_core_sink_pkg.sv
// Shared types for the mesh core sink: packet layout, node count and node id helper.
package mesh_core_sink_pkg;

    localparam int MESH_X = 4;
    localparam int MESH_Y = 4;
    localparam int NODES  = MESH_X * MESH_Y;
    localparam int SRC_W  = $clog2(NODES);
    localparam int DATA_W = 8;

    // The packet's own valid bit travels with the payload; handshaking uses i_data_val.
    typedef struct packed {
        logic              valid;
        logic [SRC_W-1:0]  source;
        logic [SRC_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } packet_t;

    localparam int PKT_W = $bits(packet_t);

    // Linear node id, row-major across the mesh.
    function automatic logic [SRC_W-1:0] node_id(input int x, input int y);
        return SRC_W'(y * MESH_X + x);
    endfunction

endpackage

// File: rtl/mesh_core_sink_fifo.sv
// Packet FIFO with registered storage; head is readable the cycle after the write edge.
// Exposes its occupancy so the sink can derive its enable from registered state.
module mesh_core_sink_fifo
    import mesh_core_sink_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  packet_t          wr_data_i,
    input  logic             rd_en_i,
    output packet_t          rd_data_o,
    output logic             rd_val_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    packet_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_wr;
    logic             do_rd;

    // Writes are dropped when full and reads ignored when empty.
    assign do_wr = wr_en_i && (count_q != CNT_W'(DEPTH));
    assign do_rd = rd_en_i && (count_q != '0);

    // Occupancy next state: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Payload storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_val_o  = (count_q != '0);
    assign rd_data_o = rd_val_o ? mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;

endmodule

// File: rtl/mesh_core_sink.sv
// Core-port receiver: terminates valid/enable flow control, buffers packets for the
// core, and checks destination and per-source in-order delivery.
// Handshake: a packet is taken on a posedge where i_data_val && o_en; o_en depends on
// registered state only. The core pops the head on a posedge where o_data_val && i_drain.
module mesh_core_sink
    import mesh_core_sink_pkg::*;
#(
    parameter int X_NODES    = 4,
    parameter int Y_NODES    = 4,
    parameter int X_LOC      = 0,
    parameter int Y_LOC      = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  packet_t          i_data,
    input  logic             i_data_val,
    output logic             o_en,
    input  logic             i_drain,
    output packet_t          o_data,
    output logic             o_data_val,
    output logic [CNT_W-1:0] o_rx_count,
    output logic             o_misroute,
    output logic             o_seq_err,
    output logic [SRC_W-1:0] o_err_source
);

    localparam int               N_NODES  = X_NODES * Y_NODES;
    localparam int               FCNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [SRC_W-1:0] LOCAL_ID = SRC_W'(Y_LOC * X_NODES + X_LOC);

    logic              reset_n_q;
    logic [FCNT_W-1:0] fifo_count;
    logic              accept;
    logic              src_ok;
    logic              dest_bad;
    logic              seq_bad;

    logic [CNT_W-1:0]  rx_count_q,   rx_count_d;
    logic              misroute_q,   misroute_d;
    logic              seq_err_q,    seq_err_d;
    logic [SRC_W-1:0]  err_source_q, err_source_d;
    logic [DATA_W-1:0] expected_q [N_NODES];
    logic [DATA_W-1:0] expected_d [N_NODES];

    // Delayed reset release so o_en rises one edge after reset_n is seen high.
    always_ff @(posedge clk) begin
        reset_n_q <= reset_n;
    end

    assign o_en   = reset_n_q && (fifo_count < FCNT_W'(FIFO_DEPTH));
    assign accept = i_data_val && o_en;

    // Sources outside the mesh cannot index the sequence table.
    if (N_NODES >= (1 << SRC_W)) begin : g_src_all
        assign src_ok = 1'b1;
    end else begin : g_src_range
        assign src_ok = (i_data.source < SRC_W'(N_NODES));
    end

    mesh_core_sink_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (accept),
        .wr_data_i (i_data),
        .rd_en_i   (i_drain),
        .rd_data_o (o_data),
        .rd_val_o  (o_data_val),
        .count_o   (fifo_count)
    );

    // Checker next state: counters, sticky flags and the per-source expected table.
    always_comb begin
        rx_count_d   = rx_count_q;
        misroute_d   = misroute_q;
        seq_err_d    = seq_err_q;
        err_source_d = err_source_q;
        expected_d   = expected_q;
        dest_bad     = (i_data.dest != LOCAL_ID) || !src_ok;
        seq_bad      = 1'b0;
        if (accept) begin
            if (rx_count_q != '1) rx_count_d = rx_count_q + CNT_W'(1);
            if (src_ok) begin
                seq_bad = (i_data.data != expected_q[i_data.source]);
                // Match or mismatch, the table follows the received data.
                expected_d[i_data.source] = i_data.data + DATA_W'(1);
            end
            if (dest_bad) misroute_d = 1'b1;
            if (seq_bad)  seq_err_d  = 1'b1;
            if (dest_bad || seq_bad) err_source_d = i_data.source;
        end
    end

    // Checker state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_count_q   <= '0;
            misroute_q   <= 1'b0;
            seq_err_q    <= 1'b0;
            err_source_q <= '0;
            for (int i = 0; i < N_NODES; i++) expected_q[i] <= DATA_W'(1);
        end else begin
            rx_count_q   <= rx_count_d;
            misroute_q   <= misroute_d;
            seq_err_q    <= seq_err_d;
            err_source_q <= err_source_d;
            expected_q   <= expected_d;
        end
    end

    assign o_rx_count   = rx_count_q;
    assign o_misroute   = misroute_q;
    assign o_seq_err    = seq_err_q;
    assign o_err_source = err_source_q;

endmodule

// File: tb/tb_mesh_core_sink.sv
// Bench for mesh_core_sink: scenario tasks with inline checks and a packet scoreboard.
module tb_mesh_core_sink;
    import mesh_core_sink_pkg::*;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    packet_t          i_data = '0;
    logic             i_data_val = 1'b0;
    logic             i_drain = 1'b0;
    logic             o_en;
    packet_t          o_data;
    logic             o_data_val;
    logic [CNT_W-1:0] o_rx_count;
    logic             o_misroute;
    logic             o_seq_err;
    logic [SRC_W-1:0] o_err_source;

    logic [PKT_W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mesh_core_sink #(
        .X_NODES(4), .Y_NODES(4), .X_LOC(0), .Y_LOC(0), .FIFO_DEPTH(4), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_data       (i_data),
        .i_data_val   (i_data_val),
        .o_en         (o_en),
        .i_drain      (i_drain),
        .o_data       (o_data),
        .o_data_val   (o_data_val),
        .o_rx_count   (o_rx_count),
        .o_misroute   (o_misroute),
        .o_seq_err    (o_seq_err),
        .o_err_source (o_err_source)
    );

    function automatic packet_t mk(input int src, input int dst, input int data);
        packet_t p;
        p.valid  = 1'b1;
        p.source = SRC_W'(src);
        p.dest   = SRC_W'(dst);
        p.data   = DATA_W'(data);
        return p;
    endfunction

    // One clock: at negedge score a pop, then record an accept; return #1 after posedge.
    task automatic cycle();
        logic [PKT_W-1:0] exp;
        @(negedge clk);
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (o_data_val && i_drain) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: o_data=%h popped with nothing expected", o_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (o_data !== exp) begin
                        errors++;
                        $display("FAIL pop_data: o_data=%h expected=%h", o_data, exp);
                    end
                end
            end
            if (i_data_val && o_en) exp_q.push_back(i_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; i_data_val = 1'b0; i_drain = 1'b0;
        cycle(); cycle();
        reset_n = 1'b1;
        cycle();
    endtask

    // Present a packet until accepted, within a bounded number of cycles.
    task automatic send(input int src, input int dst, input int data);
        logic acc;
        acc = 1'b0;
        i_data = mk(src, dst, data);
        i_data_val = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = o_en;
            cycle();
        end
        i_data_val = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: src=%0d data=%0d not accepted in 20 cycles", src, data);
        end
    endtask

    task automatic flush();
        i_drain = 1'b1;
        for (int n = 0; n < 8; n++) cycle();
        checks++;
        if (exp_q.size() != 0 || o_data_val !== 1'b0) begin
            errors++;
            $display("FAIL flush: %0d packets still expected, o_data_val=%b", exp_q.size(), o_data_val);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; i_drain = 1'b1;
        i_data = mk(3, 0, 1); i_data_val = 1'b1;
        cycle(); cycle(); cycle();
        checks++;
        if (o_en !== 1'b0 || o_data_val !== 1'b0 || o_data !== '0) begin
            errors++;
            $display("FAIL reset_fifo: o_en=%b o_data_val=%b o_data=%h, expected 0 0 0", o_en, o_data_val, o_data);
        end
        checks++;
        if (o_rx_count !== '0 || o_misroute !== 1'b0 || o_seq_err !== 1'b0 || o_err_source !== '0) begin
            errors++;
            $display("FAIL reset_checker: rx=%0d mis=%b seq=%b src=%0d, expected all 0",
                     o_rx_count, o_misroute, o_seq_err, o_err_source);
        end
        reset_n = 1'b1; i_data_val = 1'b0;
        checks++;
        if (o_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_en: o_en=%b before first high edge, expected 0", o_en);
        end
        cycle();
        checks++;
        if (o_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_en_rise: o_en=%b one edge after release, expected 1", o_en);
        end
        cycle(); cycle(); cycle();
        checks++;
        if (o_data_val !== 1'b0 || o_rx_count !== '0) begin
            errors++;
            $display("FAIL idle_drain: o_data_val=%b rx=%0d, expected 0 0", o_data_val, o_rx_count);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        i_drain = 1'b1;
        for (int d = 1; d <= 3; d++) send(3, node_id(0, 0), d);
        flush();
        checks++;
        if (o_rx_count !== CNT_W'(3) || o_misroute !== 1'b0 || o_seq_err !== 1'b0) begin
            errors++;
            $display("FAIL in_order: rx=%0d mis=%b seq=%b, expected 3 0 0", o_rx_count, o_misroute, o_seq_err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int d = 1; d <= 4; d++) send(4, 0, d);
        checks++;
        if (o_en !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full_en: o_en=%b after 4 accepts, expected 0", o_en);
        end
        i_data = mk(4, 0, 5); i_data_val = 1'b1;
        cycle(); cycle();
        checks++;
        if (o_rx_count !== CNT_W'(4) || o_en !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: rx=%0d o_en=%b while full, expected 4 0", o_rx_count, o_en);
        end
        i_drain = 1'b1;
        cycle();
        checks++;
        if (o_en !== 1'b1 || o_rx_count !== CNT_W'(4)) begin
            errors++;
            $display("FAIL b2b_after_drain: o_en=%b rx=%0d, expected 1 4", o_en, o_rx_count);
        end
        cycle();
        i_data_val = 1'b0;
        checks++;
        if (o_rx_count !== CNT_W'(5)) begin
            errors++;
            $display("FAIL b2b_fifth: rx=%0d, expected 5", o_rx_count);
        end
        flush();
    endtask

    task automatic test_seq_err();
        do_reset();
        i_drain = 1'b1;
        send(2, 0, 1);
        send(2, 0, 3);
        checks++;
        if (o_seq_err !== 1'b1 || o_err_source !== SRC_W'(2) || o_misroute !== 1'b0) begin
            errors++;
            $display("FAIL seq_gap: seq=%b src=%0d mis=%b, expected 1 2 0", o_seq_err, o_err_source, o_misroute);
        end
        send(5, 0, 9);
        checks++;
        if (o_err_source !== SRC_W'(5)) begin
            errors++;
            $display("FAIL seq_other_src: err_source=%0d, expected 5", o_err_source);
        end
        send(2, 0, 4);
        send(2, 0, 5);
        checks++;
        if (o_err_source !== SRC_W'(5) || o_misroute !== 1'b0) begin
            errors++;
            $display("FAIL seq_resync: err_source=%0d mis=%b, expected 5 0", o_err_source, o_misroute);
        end
        flush();
    endtask

    task automatic test_misroute();
        do_reset();
        send(7, 1, 1);
        checks++;
        if (o_misroute !== 1'b1 || o_err_source !== SRC_W'(7) || o_seq_err !== 1'b0) begin
            errors++;
            $display("FAIL misroute_flags: mis=%b src=%0d seq=%b, expected 1 7 0", o_misroute, o_err_source, o_seq_err);
        end
        checks++;
        if (o_data_val !== 1'b1 || o_data !== mk(7, 1, 1)) begin
            errors++;
            $display("FAIL misroute_delivered: val=%b o_data=%h, expected 1 %h", o_data_val, o_data, mk(7, 1, 1));
        end
        flush();
    endtask

    task automatic test_full_drain_reset();
        do_reset();
        for (int d = 1; d <= 4; d++) send(1, 0, d);
        i_data = mk(1, 0, 5); i_data_val = 1'b1; i_drain = 1'b1;
        cycle();
        checks++;
        if (o_rx_count !== CNT_W'(4) || o_en !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_no_accept: rx=%0d o_en=%b, expected 4 1", o_rx_count, o_en);
        end
        i_drain = 1'b0;
        cycle();
        checks++;
        if (o_rx_count !== CNT_W'(5) || o_en !== 1'b0) begin
            errors++;
            $display("FAIL full_next_accept: rx=%0d o_en=%b, expected 5 0", o_rx_count, o_en);
        end
        i_data = mk(1, 3, 6);
        reset_n = 1'b0;
        cycle();
        checks++;
        if (o_data_val !== 1'b0 || o_rx_count !== '0 || o_en !== 1'b0 || o_misroute !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: val=%b rx=%0d o_en=%b mis=%b, expected 0 0 0 0",
                     o_data_val, o_rx_count, o_en, o_misroute);
        end
        reset_n = 1'b1; i_data_val = 1'b0;
        cycle();
        send(1, 0, 1);
        checks++;
        if (o_rx_count !== CNT_W'(1) || o_seq_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_seq: rx=%0d seq=%b, expected 1 0", o_rx_count, o_seq_err);
        end
        flush();
    endtask

    task automatic test_saturate();
        do_reset();
        i_drain = 1'b1;
        for (int d = 1; d <= 10; d++) send(6, 0, d);
        checks++;
        if (o_rx_count !== CNT_W'(7) || o_seq_err !== 1'b0) begin
            errors++;
            $display("FAIL rx_saturate: rx=%0d seq=%b, expected 7 0", o_rx_count, o_seq_err);
        end
        flush();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_back_to_back();
        test_seq_err();
        test_misroute();
        test_full_drain_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
